// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial WIDTH-bit adder built around an external 1-bit
// pipelined full adder with FA_LAT cycles of latency. Bits are issued LSB
// first, and each returned carry is fed back as the carry-in of the next bit.
module serial_add_seq #(
    parameter int WIDTH  = 8,
    parameter int FA_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The index must be able to hold WIDTH, so it never wraps mid-operation.
    localparam int IDX_W = $clog2(WIDTH + 1);
    // The wait counter runs from 1 up to FA_LAT.
    localparam int CNT_W = $clog2(FA_LAT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(FA_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             accept;
    logic             capture;
    logic             last_bit;
    logic             a_bit;
    logic             b_bit;

    // A new request is taken only when no addition is in flight.
    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    // The full-adder result is valid only on the FA_LAT-th cycle after issue.
    assign capture  = (state_q == S_WAIT) && (wait_q == LAT_CNT);
    assign last_bit = (idx_q == LAST_IDX);

    // State register; reset returns to IDLE regardless of the current state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the issue/wait sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (capture) begin
                    state_d = last_bit ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = start ? S_ISSUE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Select the operand bits addressed by the current index.
    always_comb begin
        a_bit = 1'b0;
        b_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_bit = a_q[i];
                b_bit = b_q[i];
            end
        end
    end

    // Outputs decoded from state; full-adder inputs pulse only in ISSUE.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        fa_a   = 1'b0;
        fa_b   = 1'b0;
        fa_cin = 1'b0;
        case (state_q)
            S_ISSUE: begin
                busy   = 1'b1;
                fa_a   = a_bit;
                fa_b   = b_bit;
                fa_cin = carry_q;
            end
            S_WAIT: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath next values: operand load, latency counting and bit capture.
    always_comb begin
        idx_d    = idx_q;
        wait_d   = wait_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        if (accept) begin
            a_d      = a;
            b_d      = b;
            carry_d  = cin;
            idx_d    = '0;
            result_d = '0;
        end

        // The counter enters WAIT at 1 so it equals FA_LAT on the sample cycle.
        if (state_q == S_ISSUE) begin
            wait_d = CNT_W'(1);
        end else if ((state_q == S_WAIT) && !capture) begin
            wait_d = wait_q + CNT_W'(1);
        end

        if (capture) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    result_d[i] = fa_sum;
                end
            end
            carry_d = fa_cout;
            idx_d   = idx_q + IDX_W'(1);
            // The published result only changes once the final bit lands,
            // so sum/cout hold steady through the next operation.
            if (last_bit) begin
                sum_d  = result_d;
                cout_d = fa_cout;
            end
        end
    end

    // Datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q    <= '0;
            wait_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            wait_q   <= wait_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, minimum 1.
REQ-002 Parameter FA_LAT, default 3: clock cycles from full-adder input pulse to valid fa_sum/fa_cout, minimum 1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request pulse; a, b and cin are sampled in the cycle start is accepted.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  initial carry-in.
REQ-009 fa_a  output  1  bit of A sent to the downstream full adder.
REQ-010 fa_b  output  1  bit of B sent to the full adder.
REQ-011 fa_cin  output  1  carry sent to the full adder.
REQ-012 fa_sum  input  1  Sum returned by the full adder.
REQ-013 fa_cout  input  1  Carry_out returned by the full adder.
REQ-014 busy  output  1  high while an addition is in progress.
REQ-015 done  output  1  one-cycle pulse when sum and cout are valid.
REQ-016 sum  output  WIDTH  registered result.
REQ-017 cout  output  1  registered final carry.

Function
REQ-018 The block SHALL sequence one WIDTH-bit addition through a 1-bit pipelined full adder, LSB first, feeding each returned carry back as fa_cin of the next bit.
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-020 Transitions: IDLE->ISSUE on start; ISSUE->WAIT; WAIT->ISSUE after FA_LAT cycles when bits remain; WAIT->DONE after the capture of bit WIDTH-1; DONE->ISSUE on start, else DONE->IDLE.
REQ-021 start SHALL be accepted only in IDLE or DONE and ignored in ISSUE and WAIT.
REQ-022 On acceptance the block SHALL register a, b and cin, clear the bit index, clear the result register and set busy from the next cycle.
REQ-023 In an ISSUE cycle, fa_a/fa_b SHALL carry operand bit [index] and fa_cin the carry register.
REQ-024 In all other cycles fa_a, fa_b and fa_cin SHALL be 0 (pulse semantics).
REQ-025 fa_sum/fa_cout SHALL be sampled only in the cycle exactly FA_LAT cycles after the ISSUE cycle and ignored otherwise.
REQ-026 At that sample, result[index] SHALL be set to fa_sum, the carry register to fa_cout, and index SHALL be incremented.
REQ-027 Each bit SHALL occupy FA_LAT+1 cycles.
REQ-028 With start accepted in cycle 0, bit i SHALL issue in cycle 1+i*(FA_LAT+1) and done SHALL be high in cycle WIDTH*(FA_LAT+1)+1 (cycle 33 at the defaults).
REQ-029 In the done cycle, sum SHALL equal (a+b+cin) mod 2^WIDTH and cout the carry out of bit WIDTH-1.
REQ-030 sum and cout SHALL hold until the next accepted start.
REQ-031 busy SHALL be high from the cycle after acceptance through the final capture cycle, and low in DONE and IDLE.
REQ-032 A start in the DONE cycle SHALL be accepted (back-to-back operation): done still pulses for that single cycle and ISSUE of bit 0 follows immediately.
REQ-033 WIDTH=1 SHALL work with a single slot.
REQ-034 The index counter SHALL be ceil(log2(WIDTH+1)) bits wide, with no wrap-around during an operation.

Reset
REQ-035 When rst_n is low at a clock edge, the block SHALL enter IDLE and clear busy, done, sum, cout, fa_a, fa_b, fa_cin, the carry register and the index, regardless of the current state.
REQ-036 A reset mid-operation SHALL abort the addition with no done pulse.
REQ-037 Full-adder results still in flight SHALL be ignored after reset.
REQ-038 start SHALL be ignored in any cycle where rst_n is low.

Verification (bench uses a behavioural full adder with FA_LAT=3 latency; WIDTH=8)
REQ-039 a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0, done exactly in cycle 33, busy high in cycles 1-32.
REQ-040 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-041 A start pulse with different operands in cycle 10 of an operation -> ignored, and the first result is unchanged.
REQ-042 rst_n low in cycle 12 of an operation -> from the next cycle all outputs are 0 and no done appears; a new start then completes correctly.
REQ-043 start asserted in the done cycle with a=0x01, b=0x02 -> issue in the following cycle, sum=0x03 done 32 cycles later.
REQ-044 Check fa_a/fa_b/fa_cin against the issue schedule: high only in ISSUE cycles, with fa_cin equal to the previous bit's returned carry.
